// File: rtl/digit_scan_mux_pkg.sv
// Shared types and helpers for the four-digit display scanner.
package scan_pkg;

  typedef enum logic {
    GUARD = 1'b0,
    DRIVE = 1'b1
  } state_t;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [3:0]  AN_OFF     = 4'b1111;

  typedef struct packed {
    logic [3:0]  blank;
    logic [3:0]  dp;
    logic [15:0] digits;
  } disp_t;

  function automatic logic [3:0] nibble_sel(input logic [15:0] digits, input logic [1:0] idx);
    return digits[{idx, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] an_onehot_n(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/digit_scan_mux_if.sv
// Digit/anode signal bundle between the traffic-light FSM, the scanner and seven_seg_module.
interface digit_scan_mux_if;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        load;
  logic [3:0]  num_out;
  logic        dp_out;
  logic [3:0]  an;
  logic        frame_done;

  modport master (
    output digits_in, dp_in, blank_in, load,
    input  num_out, dp_out, an, frame_done
  );

  modport slave (
    input  digits_in, dp_in, blank_in, load,
    output num_out, dp_out, an, frame_done
  );
endinterface

// File: rtl/digit_scan_mux_tick_gen.sv
// Terminal-count counter; the length may change each time the count is cleared.
module scan_tick_gen #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_len,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tick
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) r_count <= '0;
    else                r_count <= r_count + WIDTH'(1);
  end

  assign o_count = r_count;
  assign o_tick  = (r_count == i_len - WIDTH'(1));

endmodule

// File: rtl/digit_scan_mux.sv
// Four-digit common-anode scanner with frame-boundary shadow register.
// Optional SCAN_LZ_BLANK_EN: auto-blank leading zeros on digits 3..1.
module digit_scan_mux
  import scan_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned GUARD_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  digit_scan_mux_if.slave        bus
);

  localparam int unsigned GUARD_LEN = (GUARD_CYCLES == 0) ? 1 : GUARD_CYCLES;
  localparam int unsigned MAX_LEN   = (REFRESH_DIV > GUARD_LEN) ? REFRESH_DIV : GUARD_LEN;
  localparam int unsigned CW        = $clog2(MAX_LEN + 1);
  localparam int unsigned IW        = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

`ifdef SCAN_LZ_BLANK_EN
  function automatic disp_t lz_blank(input disp_t d);
    disp_t r;
    logic  b3, b2, b1;
    b3 = (d.digits[15:12] == 4'd0);
    b2 = b3 && (d.digits[11:8] == 4'd0);
    b1 = b2 && (d.digits[7:4] == 4'd0);
    r = d;
    r.blank = d.blank | {b3, b2, b1, 1'b0};
    return r;
  endfunction
`else
  function automatic disp_t lz_blank(input disp_t d);
    return d;
  endfunction
`endif

  state_t        r_state;
  logic [IW-1:0] r_idx;
  disp_t         r_pending;
  disp_t         r_active;

  disp_t         w_captured;
  disp_t         w_active_next;
  state_t        w_next_state;
  logic [IW-1:0] w_next_idx;
  logic [CW-1:0] w_len;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_next_cnt;
  logic          w_tick;
  logic          w_boundary;
  logic          w_fd_next;

  scan_tick_gen #(.WIDTH(CW)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_tick),
    .i_len   (w_len),
    .o_count (w_count),
    .o_tick  (w_tick)
  );

  always_comb begin
    w_len      = (r_state == DRIVE) ? CW'(REFRESH_DIV) : CW'(GUARD_LEN);
    w_captured = {bus.blank_in, bus.dp_in, bus.digits_in};
    w_boundary = (r_state == DRIVE) && (r_idx == LAST_IDX) && w_tick;

    // A load on the boundary cycle bypasses pending straight into active.
    w_active_next = r_active;
    if (w_boundary) w_active_next = lz_blank(bus.load ? w_captured : r_pending);

    w_next_state = r_state;
    w_next_idx   = r_idx;
    if (w_tick) begin
      if (r_state == GUARD) begin
        w_next_state = DRIVE;
      end else begin
        w_next_idx   = r_idx + IW'(1);
        w_next_state = (GUARD_CYCLES == 0) ? DRIVE : GUARD;
      end
    end

    w_next_cnt = w_tick ? '0 : w_count + CW'(1);
    w_fd_next  = (w_next_state == DRIVE) && (w_next_idx == LAST_IDX) &&
                 (w_next_cnt == CW'(REFRESH_DIV - 1));
  end

  // Outputs are computed from next-state values so they line up with the state register;
  // num/dp only change when idx advances, i.e. on entry to GUARD (or DRIVE when unguarded).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= GUARD;
      r_idx          <= '0;
      r_pending      <= '0;
      r_active       <= '0;
      bus.an         <= AN_OFF;
      bus.num_out    <= '0;
      bus.dp_out     <= 1'b1;
      bus.frame_done <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_idx    <= w_next_idx;
      r_active <= w_active_next;
      if (bus.load) r_pending <= w_captured;
      bus.an         <= ((w_next_state == DRIVE) && !w_active_next.blank[w_next_idx])
                        ? an_onehot_n(w_next_idx) : AN_OFF;
      bus.num_out    <= nibble_sel(w_active_next.digits, w_next_idx);
      bus.dp_out     <= ~w_active_next.dp[w_next_idx];
      bus.frame_done <= w_fd_next;
    end
  end

endmodule
